regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 16-entry register file among NREQ requesters, using round-robin arbitration with optional bounded burst locking.
- Drives the register-address, write-enable and write-data lines into the register file's 4-to-16 write decoder. Exactly one write is issued per cycle at most.
- Registered outputs; requesters use a req/ack handshake.

---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/regfile_write_arbiter_rr_priority_picker.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 tb/tb_regfile_write_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Purpose: shared constants, state encoding and packed-field slicing helpers for the regfile write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester i owns bits [lsb +: width] of the packed addr_i / data_i buses.
  function automatic int addr_lsb(input int i);
    return i * REG_ADDR_W;
  endfunction

  function automatic int data_lsb(input int i, input int data_w);
    return i * data_w;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Purpose: requester-side req/ack bundle plus the register-file write port lines.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/addr/data until ack; the write port has none.
// Ports: req/lock/addr_i/data_i from requesters, ack back to them;
//        RegAdd/WE/WrData/grant_id/busy toward the register file decoder.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            lock;
  logic [NREQ*REG_ADDR_W-1:0] addr_i;
  logic [NREQ*DATA_W-1:0]     data_i;
  logic [NREQ-1:0]            ack;
  logic [REG_ADDR_W-1:0]      RegAdd;
  logic                       WE;
  logic [DATA_W-1:0]          WrData;
  logic [1:0]                 grant_id;
  logic                       busy;

  // Requester / testbench side.
  modport master (
    output req, lock, addr_i, data_i,
    input  ack, RegAdd, WE, WrData, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, lock, addr_i, data_i,
    output ack, RegAdd, WE, WrData, grant_id, busy
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Purpose: pick the first set request searching circularly from ptr.
// Latency: purely combinational.
// Backpressure: none; vld=0 when no request is set.
// Ports: req (per requester), ptr (search start) -> gnt (one-hot), idx, vld.
module rr_priority_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx,
  output logic            vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Modulo keeps the search inside 0..NREQ-1 even for NREQ=3.
      j = (int'(ptr) + k) % NREQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: share the register file write port among NREQ requesters, round-robin with bounded burst locking.
// Latency: ack is combinational in the request cycle; WE/RegAdd/WrData/grant_id appear one cycle later.
// Backpressure: un-acked requesters hold req/addr/data; at most one write issued per cycle.
// Ports: clk, rst (synchronous, active-high), bus (slave modport: req/lock/addr_i/data_i in,
//        ack/RegAdd/WE/WrData/grant_id/busy out).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t       state;
  logic [1:0]       ptr;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  rr_gnt;
  logic [1:0]       rr_idx;
  logic             rr_vld;

  logic [NREQ-1:0]  gnt;
  logic [1:0]       gidx;
  logic             gvld;
  logic             burst_more;

  rr_priority_picker #(.NREQ(NREQ)) u_picker (
    .req (bus.req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  // A locked owner that still requests wins outright; once it drops req the
  // picker takes over from ptr, which already points just past the owner.
  always_comb begin
    gnt  = rr_gnt;
    gidx = rr_idx;
    gvld = rr_vld;
    if (state == LOCKED && bus.req[owner]) begin
      gnt  = NREQ'(1) << owner;
      gidx = owner;
      gvld = 1'b1;
    end
  end

  assign bus.ack = rst ? '0 : gnt;

  // Stay locked only while the burst still has room after this write.
  assign burst_more = bus.lock[gidx] && ((int'(cnt) + 1) < MAX_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.WE       <= 1'b0;
      bus.RegAdd   <= '0;
      bus.WrData   <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
    end else begin
      bus.WE <= gvld;
      if (gvld) begin
        bus.RegAdd   <= bus.addr_i[addr_lsb(int'(gidx)) +: REG_ADDR_W];
        bus.WrData   <= bus.data_i[data_lsb(int'(gidx), DATA_W) +: DATA_W];
        bus.grant_id <= gidx;
        ptr          <= (int'(gidx) == NREQ - 1) ? 2'd0 : gidx + 2'd1;
        if (burst_more) begin
          state    <= LOCKED;
          owner    <= gidx;
          cnt      <= cnt + 1'b1;
          bus.busy <= 1'b1;
        end else begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
      end else begin
        state    <= IDLE;
        cnt      <= '0;
        bus.busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed self-checking bench for regfile_write_arbiter (NREQ=4, DATA_W=8, MAX_BURST=4).
// Latency: checks ack 1 time unit after driving, registered outputs 1 time unit after each rising edge.
// Backpressure: stimulus holds req until ack as the handshake requires.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  regfile_write_arbiter_if #(.NREQ(4), .DATA_W(8)) bus ();

  regfile_write_arbiter #(.NREQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the register file's 4-to-16 write decoder.
  logic [NUM_REGS-1:0] dec;
  assign dec = bus.WE ? (NUM_REGS'(1) << bus.RegAdd) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset with every requester asking and locking.
    rst        = 1'b1;
    bus.req    = 4'b1111;
    bus.lock   = 4'b1111;
    bus.addr_i = 16'h3210;
    bus.data_i = 32'hD3C2B1A0;
    #1;
    chk("rst_ack0", 32'(bus.ack), 32'h0);
    tick();
    chk("rst_ack1", 32'(bus.ack), 32'h0);
    tick();
    chk("rst_ack2", 32'(bus.ack), 32'h0);
    chk("rst_we",   32'(bus.WE), 32'h0);
    chk("rst_addr", 32'(bus.RegAdd), 32'h0);
    chk("rst_data", 32'(bus.WrData), 32'h0);
    chk("rst_gid",  32'(bus.grant_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Round-robin from ptr=0, all requesting, no lock.
    rst      = 1'b0;
    bus.lock = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ack", 32'(bus.ack), 32'(rr_exp[k]));
      tick();
      chk("rr_we",   32'(bus.WE), 32'h1);
      chk("rr_gid",  32'(bus.grant_id), 32'(k % 4));
      chk("rr_addr", 32'(bus.RegAdd), 32'(k % 4));
      chk("rr_data", 32'(bus.WrData), 32'(8'hA0 + 8'h11 * (k % 4)));
    end
    bus.req = 4'b0000;
    #1;
    chk("idle_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("idle_we",   32'(bus.WE), 32'h0);
    chk("idle_hold", 32'(bus.RegAdd), 32'h0);

    // Single write from requester 2.
    bus.req    = 4'b0100;
    bus.addr_i = 16'h0A00;
    bus.data_i = 32'h005C0000;
    #1;
    chk("sw_ack", 32'(bus.ack), 32'h4);
    tick();
    chk("sw_we",   32'(bus.WE), 32'h1);
    chk("sw_addr", 32'(bus.RegAdd), 32'hA);
    chk("sw_data", 32'(bus.WrData), 32'h5C);
    chk("sw_gid",  32'(bus.grant_id), 32'h2);
    chk("sw_dec",  32'(dec), 32'h0400);
    bus.req = 4'b0000;
    tick();
    chk("sw_we_off",  32'(bus.WE), 32'h0);
    chk("sw_addr_hd", 32'(bus.RegAdd), 32'hA);
    chk("sw_data_hd", 32'(bus.WrData), 32'h5C);

    // Burst: requester 0 locks for MAX_BURST writes, then requester 1.
    bus.addr_i = 16'h3210;
    bus.data_i = 32'hD3C2B1A0;
    bus.req    = 4'b0011;
    bus.lock   = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bu_ack", 32'(bus.ack), 32'h1);
      tick();
      chk("bu_busy", 32'(bus.busy), (k < 3) ? 32'h1 : 32'h0);
      chk("bu_gid",  32'(bus.grant_id), 32'h0);
    end
    #1;
    chk("bu_next_ack", 32'(bus.ack), 32'h2);
    tick();
    chk("bu_next_gid",  32'(bus.grant_id), 32'h1);
    chk("bu_next_busy", 32'(bus.busy), 32'h0);
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();

    // Early release: owner 0 drops req after two locked writes.
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("er_ack", 32'(bus.ack), 32'h1);
      tick();
      chk("er_busy", 32'(bus.busy), 32'h1);
      chk("er_we",   32'(bus.WE), 32'h1);
    end
    bus.req = 4'b0010;
    #1;
    chk("er_rel_ack", 32'(bus.ack), 32'h2);
    tick();
    chk("er_rel_we",   32'(bus.WE), 32'h1);
    chk("er_rel_gid",  32'(bus.grant_id), 32'h1);
    chk("er_rel_busy", 32'(bus.busy), 32'h0);
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();

    // Reset in the middle of a locked burst of requester 2.
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    #1;
    chk("rm_ack0", 32'(bus.ack), 32'h4);
    tick();
    #1;
    chk("rm_ack1", 32'(bus.ack), 32'h4);
    tick();
    chk("rm_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rm_rst_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("rm_we",      32'(bus.WE), 32'h0);
    chk("rm_busy0",   32'(bus.busy), 32'h0);
    rst      = 1'b0;
    bus.req  = 4'b0011;
    bus.lock = 4'b0000;
    #1;
    chk("rm_ptr0_ack", 32'(bus.ack), 32'h1);
    tick();
    chk("rm_post_we",  32'(bus.WE), 32'h1);
    chk("rm_post_gid", 32'(bus.grant_id), 32'h0);
    bus.req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
